// File: rtl/id_stage_pipe.sv
// MIPS32 decode stage: one instruction per cycle in, decoded fields out through a
// main + skid buffer so id_ready is a flop. Load-use hazards stall the main entry.
module id_stage_pipe #(
    parameter int PC_W        = 32,
    parameter bit ZEXT_LOGIC  = 1'b1,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [PC_W-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ld_busy,
    input  logic [4:0]      ld_wreg,
    input  logic            ex_ready,
    output logic            out_valid,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_wreg,
    output logic [31:0]     out_imm,
    output logic [5:0]      out_func,
    output logic [4:0]      out_shamt,
    output logic            out_uses_rt,
    output logic [PC_W-1:0] out_pc
);

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      wreg;
        logic [31:0]     imm;
        logic [5:0]      func;
        logic [4:0]      shamt;
        logic            uses_rt;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t dec;
    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic   ready_q, ready_d;
    logic   accept, transfer, hazard;

    always_comb begin
        dec        = '0;
        dec.opcode = if_inst[31:26];
        dec.rs     = if_inst[25:21];
        dec.rt     = if_inst[20:16];
        dec.func   = if_inst[5:0];
        dec.shamt  = if_inst[10:6];
        dec.pc     = if_pc;
        unique case (if_inst[31:26])
            6'h00:   dec.wreg = if_inst[15:11];
            6'h03:   dec.wreg = 5'd31;
            default: dec.wreg = if_inst[20:16];
        endcase
        unique case (if_inst[31:26])
            6'h0F:               dec.imm = {if_inst[15:0], 16'h0};
            6'h0C, 6'h0D, 6'h0E: dec.imm = ZEXT_LOGIC ? {16'h0, if_inst[15:0]}
                                                      : {{16{if_inst[15]}}, if_inst[15:0]};
            default:             dec.imm = {{16{if_inst[15]}}, if_inst[15:0]};
        endcase
        dec.uses_rt = if_inst[31:26] inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    end

    always_comb begin
        hazard = LOAD_USE_EN && main_vld_q && ld_busy && (ld_wreg != 5'd0) &&
                 ((ld_wreg == main_q.rs) || (main_q.uses_rt && (ld_wreg == main_q.rt)));
    end

    assign out_valid = main_vld_q & ~hazard;
    assign accept    = if_valid & ready_q & ~flush;
    assign transfer  = out_valid & ex_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || transfer) begin
            // Skid is only ever occupied behind a valid main, so it drains first.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_d     = accept ? dec : main_q;
                main_vld_d = accept;
            end
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
        ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ready_d;
        end
    end

    assign id_ready    = ready_q;
    assign out_opcode  = main_q.opcode;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_wreg    = main_q.wreg;
    assign out_imm     = main_q.imm;
    assign out_func    = main_q.func;
    assign out_shamt   = main_q.shamt;
    assign out_uses_rt = main_q.uses_rt;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: dut (default params) and dut2 (sign-extend
// logic immediates, no load-use logic) share stimulus; a monitor checks every transfer.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, ld_busy, ex_ready;
    logic [31:0] if_inst, if_pc;
    logic [4:0]  ld_wreg;

    logic        id_ready, out_valid, out_uses_rt;
    logic [5:0]  out_opcode, out_func;
    logic [4:0]  out_rs, out_rt, out_wreg, out_shamt;
    logic [31:0] out_imm, out_pc;

    logic        id_ready2, out_valid2, out_uses_rt2;
    logic [5:0]  out_opcode2, out_func2;
    logic [4:0]  out_rs2, out_rt2, out_wreg2, out_shamt2;
    logic [31:0] out_imm2, out_pc2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  opc;
        logic [4:0]  rs, rt, wreg, shamt;
        logic [5:0]  func;
        logic [31:0] imm, imm2, pc;
        logic        uses;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    id_stage_pipe #(.PC_W(32), .ZEXT_LOGIC(1'b1), .LOAD_USE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ld_busy(ld_busy), .ld_wreg(ld_wreg),
        .ex_ready(ex_ready), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rt(out_rt), .out_wreg(out_wreg), .out_imm(out_imm),
        .out_func(out_func), .out_shamt(out_shamt), .out_uses_rt(out_uses_rt),
        .out_pc(out_pc));

    id_stage_pipe #(.PC_W(32), .ZEXT_LOGIC(1'b0), .LOAD_USE_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready2), .flush(flush), .ld_busy(ld_busy), .ld_wreg(ld_wreg),
        .ex_ready(ex_ready), .out_valid(out_valid2), .out_opcode(out_opcode2),
        .out_rs(out_rs2), .out_rt(out_rt2), .out_wreg(out_wreg2), .out_imm(out_imm2),
        .out_func(out_func2), .out_shamt(out_shamt2), .out_uses_rt(out_uses_rt2),
        .out_pc(out_pc2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every transfer toward EX must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && ex_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: pc 0x%08h inst presented with empty scoreboard", out_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("opcode", {26'b0, out_opcode}, {26'b0, e.opc});
                chk("rs", {27'b0, out_rs}, {27'b0, e.rs});
                chk("rt", {27'b0, out_rt}, {27'b0, e.rt});
                chk("wreg", {27'b0, out_wreg}, {27'b0, e.wreg});
                chk("imm", out_imm, e.imm);
                chk("func", {26'b0, out_func}, {26'b0, e.func});
                chk("shamt", {27'b0, out_shamt}, {27'b0, e.shamt});
                chk("uses_rt", {31'b0, out_uses_rt}, {31'b0, e.uses});
                chk("pc", out_pc, e.pc);
                chk("dut2_valid", {31'b0, out_valid2}, 32'd1);
                chk("dut2_imm", out_imm2, e.imm2);
                chk("dut2_pc", out_pc2, e.pc);
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [4:0] wreg,
                        input logic [31:0] imm, input logic [31:0] imm2, input logic uses,
                        input bit push);
        int n;
        if (push) begin
            exp_t e;
            e.opc   = inst[31:26];
            e.rs    = inst[25:21];
            e.rt    = inst[20:16];
            e.shamt = inst[10:6];
            e.func  = inst[5:0];
            e.wreg  = wreg;
            e.imm   = imm;
            e.imm2  = imm2;
            e.uses  = uses;
            e.pc    = pc;
            q.push_back(e);
        end
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        n = 0;
        forever begin
            @(negedge clk);
            if (id_ready && !flush) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if_valid = 1'b0;
    endtask

    task automatic hz(input logic busy, input logic [4:0] w, input logic expv, input string nm);
        @(posedge clk);
        #1;
        ld_busy = busy;
        ld_wreg = w;
        @(negedge clk);
        chk(nm, {31'b0, out_valid}, {31'b0, expv});
        chk({nm, "_dut2"}, {31'b0, out_valid2}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        flush = 1'b0; ld_busy = 1'b0; ld_wreg = '0; ex_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, id_ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic decode, one-cycle latency, back-to-back stream.
        ex_ready = 1'b1;
        send(32'h012A4020, 32'h100, 5'd8, 32'h00004020, 32'h00004020, 1'b1, 1'b1);
        @(negedge clk);
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        chk("add_rs", {27'b0, out_rs}, 32'd9);
        @(posedge clk); #1;
        send(32'h3C01ABCD, 32'h104, 5'd1, 32'hABCD0000, 32'hABCD0000, 1'b0, 1'b1);
        send(32'h3421FFFF, 32'h108, 5'd1, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        send(32'h8C22FFFC, 32'h10C, 5'd2, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 1'b1);
        send(32'h0C000010, 32'h110, 5'd31, 32'h00000010, 32'h00000010, 1'b0, 1'b1);
        send(32'h3042FF00, 32'h114, 5'd2, 32'h0000FF00, 32'hFFFFFF00, 1'b0, 1'b1);
        idle(3);

        // Skid fill with EX stalled, then drain in order.
        ex_ready = 1'b0;
        send(32'hAC430008, 32'h200, 5'd3, 32'h00000008, 32'h00000008, 1'b1, 1'b1);
        send(32'h00441820, 32'h204, 5'd3, 32'h00001820, 32'h00001820, 1'b1, 1'b1);
        @(negedge clk);
        chk("skid_full_ready", {31'b0, id_ready}, 32'd0);
        chk("skid_full_valid", {31'b0, out_valid}, 32'd1);
        chk("skid_main_pc", out_pc, 32'h200);
        fork
            send(32'h3C01ABCD, 32'h208, 5'd1, 32'hABCD0000, 32'hABCD0000, 1'b0, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1 ex_ready = 1'b1;
            end
        join
        idle(4);
        chk("skid_drained", q.size(), 32'd0);

        // Load-use bubble on add $3,$2,$4.
        ex_ready = 1'b0;
        ld_busy  = 1'b1;
        ld_wreg  = 5'd2;
        send(32'h00441820, 32'h300, 5'd3, 32'h00001820, 32'h00001820, 1'b1, 1'b1);
        @(negedge clk);
        chk("hz_rs", {31'b0, out_valid}, 32'd0);
        chk("hz_rs_dut2", {31'b0, out_valid2}, 32'd1);
        hz(1'b1, 5'd4, 1'b0, "hz_rt");
        hz(1'b1, 5'd0, 1'b1, "hz_r0");
        hz(1'b1, 5'd9, 1'b1, "hz_nomatch");
        hz(1'b1, 5'd2, 1'b0, "hz_again");
        hz(1'b0, 5'd2, 1'b1, "hz_cleared");
        @(posedge clk); #1 ex_ready = 1'b1;
        idle(3);

        // Flush with both entries full and a new instruction arriving.
        ex_ready = 1'b0;
        send(32'h0C000020, 32'h400, 5'd31, 32'h00000020, 32'h00000020, 1'b0, 1'b0);
        send(32'h3421FFFF, 32'h404, 5'd1, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        if_valid = 1'b1;
        if_inst  = 32'h8C22FFFC;
        if_pc    = 32'h408;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_ready", {31'b0, id_ready}, 32'd1);
        chk("flush_valid_dut2", {31'b0, out_valid2}, 32'd0);
        @(posedge clk); #1 ex_ready = 1'b1;
        idle(4);
        send(32'h8C22FFFC, 32'h40C, 5'd2, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset between edges with both entries occupied.
        ex_ready = 1'b0;
        send(32'hAC430008, 32'h500, 5'd3, 32'h00000008, 32'h00000008, 1'b1, 1'b0);
        send(32'h00441820, 32'h504, 5'd3, 32'h00001820, 32'h00001820, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_ready", {31'b0, id_ready}, 32'd1);
        chk("async_rst_pc", out_pc, 32'd0);
        idle(2);
        rst = 1'b0;
        ex_ready = 1'b1;
        send(32'h3042FF00, 32'h600, 5'd2, 32'h0000FF00, 32'hFFFFFF00, 1'b0, 1'b1);
        idle(5);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
